// File: rtl/reg_file_pkg.sv
// rtl/reg_file_pkg.sv - shared types and constants for the scoreboarded register file
package reg_file_pkg;

  // Soft-clear sequencer states
  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } state_t;

  localparam int SIZE_DEFAULT     = 5;
  localparam int ZERO_REG_DEFAULT = 1;

  // Number of registers addressed by an address of the given width
  function automatic int depth_of(input int size);
    return 1 << size;
  endfunction

  localparam int DEPTH_DEFAULT = depth_of(SIZE_DEFAULT);

endpackage

// File: rtl/reg_file_scoreboard.sv
// rtl/reg_file_scoreboard.sv - per-register pending bits with set, clear, sweep-clear and two read taps
module reg_file_scoreboard
  import reg_file_pkg::*;
#(
  parameter int SIZE     = SIZE_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            set_en,
  input  logic [SIZE-1:0] set_addr,
  input  logic            clr_en,
  input  logic [SIZE-1:0] clr_addr,
  input  logic            sweep_en,
  input  logic [SIZE-1:0] sweep_addr,
  input  logic [SIZE-1:0] rd_addr_1,
  input  logic [SIZE-1:0] rd_addr_2,
  output logic            pend_1,
  output logic            pend_2
);

  localparam int DEPTH = depth_of(SIZE);

  logic [DEPTH-1:0] pend;

  // Sweep beats everything; a set beats a writeback clear on the same entry
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        if (sweep_en && sweep_addr == SIZE'(i)) begin
          pend[i] <= 1'b0;
        end else if (set_en && set_addr == SIZE'(i) && !(i == 0 && ZERO_REG != 0)) begin
          pend[i] <= 1'b1;
        end else if (clr_en && clr_addr == SIZE'(i)) begin
          pend[i] <= 1'b0;
        end
      end
    end
  end

  // Read taps come straight from the flops; register 0 is masked when hardwired
  always_comb begin
    pend_1 = pend[rd_addr_1] && !(ZERO_REG != 0 && rd_addr_1 == '0);
    pend_2 = pend[rd_addr_2] && !(ZERO_REG != 0 && rd_addr_2 == '0);
  end

endmodule

// File: rtl/reg_file_sb.sv
// rtl/reg_file_sb.sv - register file with write bypass, zero register, pending scoreboard and soft-clear sweep
module reg_file_sb
  import reg_file_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int SIZE     = SIZE_DEFAULT,
  parameter int ZERO_REG = ZERO_REG_DEFAULT
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             reg_write_i,
  input  logic [SIZE-1:0]  write_register_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [SIZE-1:0]  read_register_1_i,
  input  logic [SIZE-1:0]  read_register_2_i,
  output logic [WIDTH-1:0] read_data_1_o,
  output logic [WIDTH-1:0] read_data_2_o,
  input  logic             pend_set_i,
  input  logic [SIZE-1:0]  pend_reg_i,
  output logic             pend_1_o,
  output logic             pend_2_o,
  input  logic             clear_i,
  output logic             busy_o
);

  localparam int DEPTH = depth_of(SIZE);

  state_t           state;
  logic [SIZE-1:0]  cnt;
  logic [WIDTH-1:0] regs [DEPTH];
  logic             wr_ok;

  // A write lands only outside the sweep and never on a hardwired zero register
  assign wr_ok = reg_write_i && !busy_o && !(ZERO_REG != 0 && write_register_i == '0);

  // Sequencer: one entry cleared per cycle, busy_o registered alongside the state
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      busy_o <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (clear_i) begin
            state  <= ST_CLEAR;
            cnt    <= '0;
            busy_o <= 1'b1;
          end
        end
        ST_CLEAR: begin
          cnt <= cnt + SIZE'(1);
          if (cnt == SIZE'(DEPTH - 1)) begin
            state  <= ST_IDLE;
            busy_o <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_o <= 1'b0;
        end
      endcase
    end
  end

  // Data array: sweep clears the counter entry, otherwise the write port updates
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        regs[i] <= '0;
      end
    end else if (busy_o) begin
      regs[cnt] <= '0;
    end else if (wr_ok) begin
      regs[write_register_i] <= write_data_i;
    end
  end

  // Read port 1: zero register first, then same-cycle bypass, then the array
  always_comb begin
    if (ZERO_REG != 0 && read_register_1_i == '0) begin
      read_data_1_o = '0;
    end else if (wr_ok && write_register_i == read_register_1_i) begin
      read_data_1_o = write_data_i;
    end else begin
      read_data_1_o = regs[read_register_1_i];
    end
  end

  // Read port 2: same selection as port 1
  always_comb begin
    if (ZERO_REG != 0 && read_register_2_i == '0) begin
      read_data_2_o = '0;
    end else if (wr_ok && write_register_i == read_register_2_i) begin
      read_data_2_o = write_data_i;
    end else begin
      read_data_2_o = regs[read_register_2_i];
    end
  end

  reg_file_scoreboard #(
    .SIZE     (SIZE),
    .ZERO_REG (ZERO_REG)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .set_en     (pend_set_i && !busy_o),
    .set_addr   (pend_reg_i),
    .clr_en     (reg_write_i && !busy_o),
    .clr_addr   (write_register_i),
    .sweep_en   (busy_o),
    .sweep_addr (cnt),
    .rd_addr_1  (read_register_1_i),
    .rd_addr_2  (read_register_2_i),
    .pend_1     (pend_1_o),
    .pend_2     (pend_2_o)
  );

endmodule

// File: tb/tb_reg_file_sb.sv
// tb/tb_reg_file_sb.sv - directed vector bench for reg_file_sb
module tb_reg_file_sb;

  logic        clk;
  logic        reset;
  logic        reg_write_i;
  logic [4:0]  write_register_i;
  logic [31:0] write_data_i;
  logic [4:0]  read_register_1_i;
  logic [4:0]  read_register_2_i;
  logic [31:0] read_data_1_o;
  logic [31:0] read_data_2_o;
  logic        pend_set_i;
  logic [4:0]  pend_reg_i;
  logic        pend_1_o;
  logic        pend_2_o;
  logic        clear_i;
  logic        busy_o;

  int total  = 0;
  int passed = 0;

  reg_file_sb #(.WIDTH(32), .SIZE(5), .ZERO_REG(1)) dut (
    .clk               (clk),
    .reset             (reset),
    .reg_write_i       (reg_write_i),
    .write_register_i  (write_register_i),
    .write_data_i      (write_data_i),
    .read_register_1_i (read_register_1_i),
    .read_register_2_i (read_register_2_i),
    .read_data_1_o     (read_data_1_o),
    .read_data_2_o     (read_data_2_o),
    .pend_set_i        (pend_set_i),
    .pend_reg_i        (pend_reg_i),
    .pend_1_o          (pend_1_o),
    .pend_2_o          (pend_2_o),
    .clear_i           (clear_i),
    .busy_o            (busy_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic        ps;
    logic [4:0]  preg;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [31:0] e1;
    logic [31:0] e2;
    logic        ep1;
    logic        ep2;
  } vec_t;

  vec_t vecs[11];

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic ps, logic [4:0] pr,
                              logic [4:0] rs, logic [4:0] rt, logic [31:0] e1, logic [31:0] e2,
                              logic ep1, logic ep2);
    vec_t v;
    v.we = we; v.waddr = wa; v.wdata = wd; v.ps = ps; v.preg = pr;
    v.rs = rs; v.rt = rt; v.e1 = e1; v.e2 = e2; v.ep1 = ep1; v.ep2 = ep2;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    reg_write_i = 1'b0; write_register_i = '0; write_data_i = '0;
    pend_set_i = 1'b0; pend_reg_i = '0; clear_i = 1'b0;
  endtask

  initial begin
    int n;
    reset = 1'b0;
    idle_inputs();
    read_register_1_i = '0;
    read_register_2_i = '0;

    vecs[0]  = mk(0, 0, 32'h0,        0, 0, 5, 31, 32'h0,        32'h0,        0, 0);
    vecs[1]  = mk(1, 7, 32'hDEADBEEF, 0, 0, 7, 0,  32'hDEADBEEF, 32'h0,        0, 0);
    vecs[2]  = mk(0, 0, 32'h0,        0, 0, 7, 5,  32'hDEADBEEF, 32'h0,        0, 0);
    vecs[3]  = mk(1, 0, 32'h1234,     1, 0, 0, 7,  32'h0,        32'hDEADBEEF, 0, 0);
    vecs[4]  = mk(0, 0, 32'h0,        0, 0, 0, 7,  32'h0,        32'hDEADBEEF, 0, 0);
    vecs[5]  = mk(0, 0, 32'h0,        1, 3, 3, 0,  32'h0,        32'h0,        0, 0);
    vecs[6]  = mk(1, 3, 32'h55,       0, 0, 3, 7,  32'h55,       32'hDEADBEEF, 1, 0);
    vecs[7]  = mk(1, 4, 32'hA5A5,     1, 4, 3, 4,  32'h55,       32'hA5A5,     0, 0);
    vecs[8]  = mk(0, 0, 32'h0,        0, 0, 4, 3,  32'hA5A5,     32'h55,       1, 0);
    vecs[9]  = mk(1, 4, 32'h77,       0, 0, 4, 3,  32'h77,       32'h55,       1, 0);
    vecs[10] = mk(0, 0, 32'h0,        0, 0, 4, 4,  32'h77,       32'h77,       0, 0);

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    check("reset_busy", {31'b0, busy_o}, 32'h0);

    for (int i = 0; i < 11; i++) begin
      reg_write_i = vecs[i].we; write_register_i = vecs[i].waddr; write_data_i = vecs[i].wdata;
      pend_set_i = vecs[i].ps; pend_reg_i = vecs[i].preg;
      read_register_1_i = vecs[i].rs; read_register_2_i = vecs[i].rt;
      #1;
      check($sformatf("v%0d_rd1", i), read_data_1_o, vecs[i].e1);
      check($sformatf("v%0d_rd2", i), read_data_2_o, vecs[i].e2);
      check($sformatf("v%0d_p1", i), {31'b0, pend_1_o}, {31'b0, vecs[i].ep1});
      check($sformatf("v%0d_p2", i), {31'b0, pend_2_o}, {31'b0, vecs[i].ep2});
      tick();
    end
    idle_inputs();

    // Fill R1..R31 with their index, then sweep
    for (int r = 1; r < 32; r++) begin
      reg_write_i = 1'b1; write_register_i = 5'(r); write_data_i = 32'(r);
      tick();
    end
    idle_inputs();
    read_register_1_i = 5'd20; read_register_2_i = 5'd2;
    #1;
    check("pre_clear_r20", read_data_1_o, 32'd20);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n = 0;
    while (busy_o && n < 100) begin
      if (n == 15) clear_i = 1'b1;
      if (n == 20) begin
        reg_write_i = 1'b1; write_register_i = 5'd9; write_data_i = 32'hFFFF;
        read_register_1_i = 5'd9;
      end
      #1;
      if (n == 5) begin
        check("mid_sweep_r20_old", read_data_1_o, 32'd20);
        check("mid_sweep_r2_cleared", read_data_2_o, 32'd0);
      end
      if (n == 20) check("busy_no_bypass_r9", read_data_1_o, 32'd0);
      tick();
      idle_inputs();
      n++;
    end
    check("busy_cycles", 32'(n), 32'd32);
    read_register_1_i = 5'd9;
    #1;
    check("r9_write_dropped", read_data_1_o, 32'd0);
    for (int r = 0; r < 32; r++) begin
      read_register_1_i = 5'(r);
      #1;
      check($sformatf("post_sweep_r%0d", r), read_data_1_o, 32'd0);
    end

    // Reset mid-sweep
    tick();
    reg_write_i = 1'b1; write_register_i = 5'd31; write_data_i = 32'd31;
    tick();
    reg_write_i = 1'b1; write_register_i = 5'd5; write_data_i = 32'd5;
    pend_set_i = 1'b1; pend_reg_i = 5'd6;
    tick();
    idle_inputs();
    read_register_1_i = 5'd6; read_register_2_i = 5'd31;
    #1;
    check("pre_reset_pend6", {31'b0, pend_1_o}, 32'h1);
    check("pre_reset_r31", read_data_2_o, 32'd31);
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
    n = 0;
    while (busy_o && n < 10) begin
      tick();
      n++;
    end
    check("reached_cycle10", 32'(n), 32'd10);
    reset = 1'b0;
    #1;
    check("reset_busy_low", {31'b0, busy_o}, 32'h0);
    check("reset_pend6", {31'b0, pend_1_o}, 32'h0);
    for (int r = 0; r < 32; r++) begin
      read_register_2_i = 5'(r);
      #1;
      check($sformatf("reset_r%0d", r), read_data_2_o, 32'd0);
    end
    tick();
    reset = 1'b1;
    reg_write_i = 1'b1; write_register_i = 5'd2; write_data_i = 32'h22;
    tick();
    idle_inputs();
    read_register_1_i = 5'd2;
    #1;
    check("post_reset_write_r2", read_data_1_o, 32'h22);
    check("post_reset_busy", {31'b0, busy_o}, 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
